// File: rtl/input_register.sv
// input_register: parameterised-width operand holding register for the ALU inputs.
// Captures in_data on a rising clk edge while load is high and otherwise holds it.
// The loaded flag tells downstream logic that the operand has been written since
// the last reset.
//
// Optional feature macro: INPUT_REGISTER_PARITY_EN
//   When defined, a parity output carries the XOR of all bits of out_data.
//   The parity is taken from the register, so reset drives it to ^RESET_VALUE.
//
// Reset is asynchronous and active-high. It clears the register as soon as it is
// asserted, and it overrides a load on the same edge.
module input_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               load,
  output logic [WIDTH-1:0]   out_data,
`ifdef INPUT_REGISTER_PARITY_EN
  output logic               loaded,
  output logic               parity
`else
  output logic               loaded
`endif
);

  // Data and status live in separate flops so the status flag does not depend on
  // the data value. Loading a value equal to the current contents still sets it.
  logic [WIDTH-1:0] data_q;
  logic             loaded_q;

  // Capture in_data on a load edge. Reset clears the register asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (load) begin
      data_q <= in_data;
    end
  end

  // Set the loaded flag on the first load after reset and keep it set until the
  // next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded_q <= 1'b0;
    end else if (load) begin
      loaded_q <= 1'b1;
    end
  end

  // Outputs come straight from the flops; in_data has no combinational path to
  // out_data.
  assign out_data = data_q;
  assign loaded   = loaded_q;

`ifdef INPUT_REGISTER_PARITY_EN
  // Even parity of the stored operand, derived combinationally from the register.
  assign parity = ^data_q;
`endif

endmodule

// File: tb/tb_input_register.sv
// tb_input_register: self-checking bench for input_register (WIDTH = 8).
// A behavioural model (m_data / m_loaded) is updated from the documented rules at
// each rising edge and whenever reset is asserted. Outputs are sampled 1 ns after
// the rising edge, or between edges for the asynchronous reset cases.
module tb_input_register;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic         loaded;
`ifdef INPUT_REGISTER_PARITY_EN
  logic         parity;
`endif

  // Behavioural reference state and scoreboard.
  logic [W-1:0] m_data;
  logic         m_loaded;
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           passes = 0;

  input_register #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .load     (load),
    .out_data (out_data),
`ifdef INPUT_REGISTER_PARITY_EN
    .loaded   (loaded),
    .parity   (parity)
`else
    .loaded   (loaded)
`endif
  );

  // Clock and global timeout.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passes %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

  // Wait for one rising edge and apply the register rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_data   = '0;
      m_loaded = 1'b0;
    end else if (load) begin
      m_data   = in_data;
      m_loaded = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; in_data = 8'h00;
    m_data = '0; m_loaded = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h00) $display("FAIL reset_async_data: got %h expected 00", out_data);
    else passes++;
    tick();
    checks++;
    if (out_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", out_data);
    else passes++;
    checks++;
    if (loaded !== 1'b0) $display("FAIL reset_loaded: got %b expected 0", loaded);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if (out_data !== m_data) $display("FAIL release_idle_data: got %h expected %h", out_data, m_data);
    else passes++;
    checks++;
    if (loaded !== 1'b0) $display("FAIL release_idle_loaded: got %b expected 0", loaded);
    else passes++;
  endtask

  task automatic test_load();
    in_data = 8'hAA; load = 1'b1;
    tick();
    checks++;
    if (out_data !== 8'hAA) $display("FAIL load_data: got %h expected aa", out_data);
    else passes++;
    checks++;
    if (loaded !== 1'b1) $display("FAIL load_loaded: got %b expected 1", loaded);
    else passes++;
    load = 1'b0; in_data = 8'h3C;
    tick();
    checks++;
    if (out_data !== 8'hAA) $display("FAIL load_hold: got %h expected aa", out_data);
    else passes++;
  endtask

  task automatic test_reload();
    in_data = 8'hF0; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (out_data !== 8'hF0) $display("FAIL reload_data: got %h expected f0", out_data);
    else passes++;
`ifdef INPUT_REGISTER_PARITY_EN
    checks++;
    if (parity !== 1'b0) $display("FAIL reload_parity: got %b expected 0", parity);
    else passes++;
`endif
  endtask

  task automatic test_hold();
    in_data = 8'h0F; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_data !== 8'hF0) $display("FAIL hold_data_%0d: got %h expected f0", i, out_data);
      else passes++;
    end
    checks++;
    if (loaded !== 1'b1) $display("FAIL hold_loaded: got %b expected 1", loaded);
    else passes++;
  endtask

  task automatic test_async_reset();
    // Reset asserted between edges must clear outputs before the next edge.
    #2;
    reset = 1'b1;
    m_data = '0; m_loaded = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h00) $display("FAIL async_reset_data: got %h expected 00", out_data);
    else passes++;
    checks++;
    if (loaded !== 1'b0) $display("FAIL async_reset_loaded: got %b expected 0", loaded);
    else passes++;
    // A load on an edge while reset is high is ignored.
    in_data = 8'h55; load = 1'b1;
    tick();
    checks++;
    if (out_data !== 8'h00) $display("FAIL reset_priority_data: got %h expected 00", out_data);
    else passes++;
    checks++;
    if (loaded !== 1'b0) $display("FAIL reset_priority_loaded: got %b expected 0", loaded);
    else passes++;
    // After release, nothing is loaded until an edge with load high.
    load = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (out_data !== 8'h00 || loaded !== 1'b0)
      $display("FAIL post_reset_idle: got %h/%b expected 00/0", out_data, loaded);
    else passes++;
  endtask

  task automatic test_same_value();
    // Loading the value already held (the reset value) must still set loaded.
    in_data = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (out_data !== 8'h00 || loaded !== 1'b1)
      $display("FAIL same_value_load: got %h/%b expected 00/1", out_data, loaded);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      in_data = W'($urandom_range(0, 255)); load = 1'b1;
      exp_q.push_back(in_data);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) $display("FAIL back_to_back_%0d: got %h expected %h", i, out_data, exp);
      else passes++;
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      in_data = W'($urandom_range(0, 255));
      load    = ($urandom_range(0, 1) == 1);
      reset   = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (out_data !== m_data || loaded !== m_loaded)
        $display("FAIL random_%0d: got %h/%b expected %h/%b", i, out_data, loaded, m_data, m_loaded);
      else passes++;
`ifdef INPUT_REGISTER_PARITY_EN
      checks++;
      if (parity !== 1'($countones(m_data) % 2))
        $display("FAIL random_parity_%0d: got %b expected %0d", i, parity, $countones(m_data) % 2);
      else passes++;
`endif
    end
    reset = 1'b0; load = 1'b0;
  endtask

`ifdef INPUT_REGISTER_PARITY_EN
  task automatic test_parity();
    in_data = 8'h07; load = 1'b1;
    tick();
    checks++;
    if (parity !== 1'b1) $display("FAIL parity_07: got %b expected 1", parity);
    else passes++;
    in_data = 8'h03;
    tick();
    load = 1'b0;
    checks++;
    if (parity !== 1'b0) $display("FAIL parity_03: got %b expected 0", parity);
    else passes++;
  endtask
`endif

  // Run the scenarios in sequence, then print the summary.
  initial begin
    test_reset();
    test_load();
    test_reload();
    test_hold();
    test_async_reset();
    test_same_value();
    test_back_to_back();
`ifdef INPUT_REGISTER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
